// File: rtl/tqvp_prism_hostif.sv
// TinyQV host interface for a PRISM core: control register, capture FIFO and masked interrupts.
// Optional PRISM_HOSTIF_TIMESTAMP_EN stores a 16-bit cycle stamp with each capture in FDATA[31:16].
module tqvp_prism_hostif #(
    parameter int OUT_W       = 9,
    parameter int EXTRA_W     = 9,
    parameter int FIFO_DEPTH  = 4,
    parameter int FIFO_THRESH = 2,
    parameter int EXT_IRQ     = 1,
    localparam int EXT_W      = (EXT_IRQ > 0) ? EXT_IRQ : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         address,
    input  logic [31:0]        data_in,
    input  logic [1:0]         data_write_n,
    input  logic [1:0]         data_read_n,
    output logic [31:0]        data_out,
    output logic               data_ready,
    input  logic               prism_halt,
    input  logic [OUT_W-1:0]   prism_out,
    input  logic               cap_strobe,
    input  logic [EXT_W-1:0]   ext_irq,
    output logic               prism_enable,
    output logic               prism_reset,
    output logic [EXTRA_W-1:0] extra_in,
    output logic               user_interrupt
);
    localparam int NUM_IRQ = 3 + EXT_IRQ;
    localparam int PW      = $clog2(FIFO_DEPTH);
    localparam int CW      = 5;
`ifdef PRISM_HOSTIF_TIMESTAMP_EN
    localparam int ENT_W   = 16 + OUT_W;
`else
    localparam int ENT_W   = OUT_W;
`endif

    logic               en_q, dbg_q, rd_act_q, irq_q;
    logic [EXTRA_W-1:0] extra_q;
    logic [NUM_IRQ-1:0] istat_q, istat_d, imask_q, lvl, lvl_q, set;
    logic [PW-1:0]      rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]      count_q, count_d;
    logic [ENT_W-1:0]   mem_q [FIFO_DEPTH];
    logic [ENT_W-1:0]   wdata, head;
    logic               wr_en, rd_act, rd_start, empty, full, flush, pop, push, ovf;

    assign wr_en    = (data_write_n == 2'b10);
    assign rd_act   = (data_read_n != 2'b11);
    assign rd_start = rd_act & ~rd_act_q;
    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(FIFO_DEPTH));
    assign flush    = wr_en & (address == 6'h00) & data_in[2];
    assign pop      = rd_start & (address == 6'h0C) & ~empty;
    // A pop frees the slot the tail is about to overwrite, so a full FIFO can still accept.
    assign push     = cap_strobe & (~full | pop) & ~flush;
    assign ovf      = cap_strobe & full & ~pop & ~flush;
    assign head     = mem_q[rd_ptr_q];

`ifdef PRISM_HOSTIF_TIMESTAMP_EN
    logic [15:0] stamp_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) stamp_q <= '0;
        else        stamp_q <= stamp_q + 16'd1;
    assign wdata = {stamp_q, prism_out};
`else
    assign wdata = prism_out;
`endif

    always_comb begin
        lvl    = '0;
        lvl[0] = prism_halt;
        lvl[1] = (count_q >= CW'(FIFO_THRESH));
        for (int i = 0; i < EXT_IRQ; i++) lvl[3+i] = ext_irq[i];
        set    = lvl & ~lvl_q;
        set[2] = ovf;
        // Set is OR-ed in after the clear so a coincident event is never lost.
        istat_d = (istat_q & ~((wr_en && address == 6'h04) ? data_in[NUM_IRQ-1:0] : '0)) | set;
        count_d = flush ? '0 : count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q     <= 1'b0;
            dbg_q    <= 1'b0;
            rd_act_q <= 1'b0;
            irq_q    <= 1'b0;
            extra_q  <= '0;
            istat_q  <= '0;
            imask_q  <= '0;
            lvl_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            rd_act_q <= rd_act;
            lvl_q    <= lvl;
            istat_q  <= istat_d;
            irq_q    <= |(istat_q & imask_q);
            count_q  <= count_d;
            if (wr_en && address == 6'h00) begin
                en_q  <= data_in[0];
                dbg_q <= data_in[1];
            end
            if (wr_en && address == 6'h08) imask_q <= data_in[NUM_IRQ-1:0];
            if (wr_en && address == 6'h18) extra_q <= data_in[EXTRA_W-1:0];
            if (push) mem_q[wr_ptr_q] <= wdata;
            if (flush) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
            end else begin
                if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
                if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            end
        end
    end

    always_comb begin
        data_out = '0;
        case (address)
            6'h00: data_out = {30'd0, dbg_q, en_q};
            6'h04: data_out = 32'(istat_q);
            6'h08: data_out = 32'(imask_q);
            6'h0C: if (!empty) begin
                data_out[OUT_W-1:0] = head[OUT_W-1:0];
`ifdef PRISM_HOSTIF_TIMESTAMP_EN
                data_out[31:16]     = head[ENT_W-1:OUT_W];
`endif
            end
            6'h10: begin
                data_out[CW-1:0] = count_q;
                data_out[8]      = empty;
                data_out[9]      = full;
            end
            6'h18: data_out = 32'(extra_q);
            default: data_out = '0;
        endcase
    end

    assign data_ready     = 1'b1;
    assign prism_enable   = en_q;
    assign prism_reset    = dbg_q;
    assign extra_in       = extra_q;
    assign user_interrupt = irq_q;
endmodule

// File: tb/tb_tqvp_prism_hostif.sv
// Directed plus randomized bench for tqvp_prism_hostif against a queue-based register model.
module tb_tqvp_prism_hostif;
    localparam int DEPTH  = 4;
    localparam int THRESH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  address = '0;
    logic [31:0] data_in = '0;
    logic [1:0]  data_write_n = 2'b11;
    logic [1:0]  data_read_n = 2'b11;
    logic [31:0] data_out;
    logic        data_ready;
    logic        prism_halt = 1'b0;
    logic [8:0]  prism_out = '0;
    logic        cap_strobe = 1'b0;
    logic [0:0]  ext_irq = '0;
    logic        prism_enable, prism_reset, user_interrupt;
    logic [8:0]  extra_in;

    int n_cmp = 0;
    int n_err = 0;

    tqvp_prism_hostif #(.OUT_W(9), .EXTRA_W(9), .FIFO_DEPTH(DEPTH), .FIFO_THRESH(THRESH), .EXT_IRQ(1)) dut (
        .clk(clk), .rst_n(rst_n), .address(address), .data_in(data_in),
        .data_write_n(data_write_n), .data_read_n(data_read_n), .data_out(data_out),
        .data_ready(data_ready), .prism_halt(prism_halt), .prism_out(prism_out),
        .cap_strobe(cap_strobe), .ext_irq(ext_irq), .prism_enable(prism_enable),
        .prism_reset(prism_reset), .extra_in(extra_in), .user_interrupt(user_interrupt));

    always #5 clk = ~clk;

    // Reference model state
    bit       m_en, m_dr, m_irq, halt_p, thr_p, ext_p, rdact_p;
    bit [8:0] m_extra;
    bit [3:0] m_istat, m_imask;
    int       q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [5:0] a);
        logic [31:0] r = '0;
        case (a)
            6'h00: r = {30'd0, m_dr, m_en};
            6'h04: r = 32'(m_istat);
            6'h08: r = 32'(m_imask);
            6'h0C: r = (q.size() > 0) ? q[0] : 0;
            6'h10: r = (q.size() == DEPTH ? 32'h200 : 32'h0) | (q.size() == 0 ? 32'h100 : 32'h0) | q.size();
            6'h18: r = 32'(m_extra);
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic void model_step();
        bit       wr    = (data_write_n == 2'b10);
        bit       rdact = (data_read_n != 2'b11);
        bit       flush = wr && address == 6'h00 && data_in[2];
        int       n     = q.size();
        bit       full  = (n == DEPTH);
        bit       pop   = rdact && !rdact_p && address == 6'h0C && n > 0;
        bit [3:0] set;
        set[0] = prism_halt && !halt_p;
        set[1] = (n >= THRESH) && !thr_p;
        set[2] = cap_strobe && full && !pop && !flush;
        set[3] = ext_irq[0] && !ext_p;
        m_irq = |(m_istat & m_imask);
        if (wr && address == 6'h04) m_istat &= ~data_in[3:0];
        m_istat |= set;
        if (wr && address == 6'h08) m_imask = data_in[3:0];
        if (wr && address == 6'h00) {m_dr, m_en} = data_in[1:0];
        if (wr && address == 6'h18) m_extra = data_in[8:0];
        if (flush) q.delete();
        else begin
            if (pop) void'(q.pop_front());
            if (cap_strobe && (!full || pop)) q.push_back(int'(prism_out));
        end
        halt_p  = prism_halt;
        thr_p   = (n >= THRESH);
        ext_p   = ext_irq[0];
        rdact_p = rdact;
    endfunction

    task automatic step();
        #1;
        chk("data_out", data_out, exp_rd(address));
        model_step();
        @(posedge clk);
        #1;
        chk("prism_enable", prism_enable, m_en);
        chk("prism_reset", prism_reset, m_dr);
        chk("extra_in", extra_in, m_extra);
        chk("user_interrupt", user_interrupt, m_irq);
    endtask

    task automatic wr32(input logic [5:0] a, input logic [31:0] d);
        address = a; data_in = d; data_write_n = 2'b10;
        step();
        data_write_n = 2'b11;
    endtask

    task automatic peek(input string tag, input logic [5:0] a, input logic [31:0] mask, input logic [31:0] exp);
        address = a;
        #1;
        chk(tag, data_out & mask, exp);
    endtask

    task automatic rd(input string tag, input logic [31:0] exp);
        address = 6'h0C; data_read_n = 2'b10;
        #1;
        chk(tag, data_out, exp);
        step();
        data_read_n = 2'b11;
        step();
    endtask

    task automatic strobe(input logic [8:0] v);
        cap_strobe = 1'b1; prism_out = v;
        step();
        cap_strobe = 1'b0;
    endtask

    logic [8:0] r [5];
    logic [8:0] nv;
    logic [5:0] alist [8] = '{6'h00, 6'h04, 6'h08, 6'h0C, 6'h10, 6'h14, 6'h18, 6'h3C};

    initial begin
        // Reset values
        #2;
        peek("rst_ctrl", 6'h00, 32'hFFFF_FFFF, 32'h0);
        peek("rst_istat", 6'h04, 32'hFFFF_FFFF, 32'h0);
        peek("rst_imask", 6'h08, 32'hFFFF_FFFF, 32'h0);
        peek("rst_fdata", 6'h0C, 32'hFFFF_FFFF, 32'h0);
        peek("rst_fstat", 6'h10, 32'hFFFF_FFFF, 32'h100);
        peek("rst_extra", 6'h18, 32'hFFFF_FFFF, 32'h0);
        chk("rst_irq", user_interrupt, 1'b0);
        chk("rst_en", prism_enable, 1'b0);
        chk("rst_prst", prism_reset, 1'b0);
        chk("rst_ready", data_ready, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Control register and width filtering
        wr32(6'h00, 32'h3);
        chk("ctrl_en", prism_enable, 1'b1);
        chk("ctrl_prst", prism_reset, 1'b1);
        address = 6'h00; data_in = 32'h0; data_write_n = 2'b01;
        step();
        data_write_n = 2'b11;
        chk("ctrl_16b_ignored", prism_enable, 1'b1);
        nv = 9'($urandom);
        wr32(6'h18, {23'($urandom), nv});
        chk("extra", extra_in, nv);

        // Capture, threshold and pop order
        strobe(9'h011); strobe(9'h022); strobe(9'h033);
        peek("fstat_3", 6'h10, 32'hFFFF_FFFF, 32'h3);
        peek("istat_thr", 6'h04, 32'h2, 32'h2);
        rd("pop_0", 32'h011);
        rd("pop_1", 32'h022);
        rd("pop_2", 32'h033);
        rd("pop_empty", 32'h0);
        peek("fstat_empty", 6'h10, 32'hFFFF_FFFF, 32'h100);

        // Overflow and masked interrupt
        for (int i = 0; i < 5; i++) begin
            r[i] = 9'($urandom);
            strobe(r[i]);
        end
        peek("fstat_full", 6'h10, 32'hFFFF_FFFF, 32'h204);
        peek("istat_ovf", 6'h04, 32'h4, 32'h4);
        wr32(6'h08, 32'h4);
        step();
        chk("irq_on", user_interrupt, 1'b1);
        wr32(6'h04, 32'h4);
        peek("istat_w1c", 6'h04, 32'h4, 32'h0);
        step();
        chk("irq_off", user_interrupt, 1'b0);

        // Push and pop together while full
        nv = 9'($urandom);
        address = 6'h0C; data_read_n = 2'b10; cap_strobe = 1'b1; prism_out = nv;
        #1;
        chk("fullpp_head", data_out, 32'(r[0]));
        step();
        cap_strobe = 1'b0; data_read_n = 2'b11;
        step();
        peek("fullpp_fstat", 6'h10, 32'hFFFF_FFFF, 32'h204);
        peek("fullpp_noovf", 6'h04, 32'h4, 32'h0);
        rd("fullpp_pop1", 32'(r[1]));
        rd("fullpp_pop2", 32'(r[2]));
        rd("fullpp_pop3", 32'(r[3]));
        rd("fullpp_popn", 32'(nv));

        // Halt rise against a same-cycle W1C, then flush against a strobe
        prism_halt = 1'b1; address = 6'h04; data_in = 32'h1; data_write_n = 2'b10;
        step();
        data_write_n = 2'b11;
        peek("halt_set_wins", 6'h04, 32'h1, 32'h1);
        strobe(9'h0AA); strobe(9'h0BB);
        address = 6'h00; data_in = 32'h5; data_write_n = 2'b10; cap_strobe = 1'b1; prism_out = 9'h0CC;
        step();
        data_write_n = 2'b11; cap_strobe = 1'b0;
        peek("flush_fstat", 6'h10, 32'hFFFF_FFFF, 32'h100);
        prism_halt = 1'b0;
        step();

        // Randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            cap_strobe   = 1'($urandom);
            prism_out    = 9'($urandom);
            if ($urandom_range(0, 7) == 0) prism_halt = ~prism_halt;
            if ($urandom_range(0, 5) == 0) ext_irq = ~ext_irq;
            address      = alist[$urandom_range(0, 7)];
            data_read_n  = 2'($urandom);
            data_write_n = ($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'b11;
            data_in      = $urandom;
            if (address == 6'h00 && $urandom_range(0, 2) != 0) data_in[2] = 1'b0;
            step();
        end
        data_write_n = 2'b11; data_read_n = 2'b11; cap_strobe = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
